// File: rtl/game_pkg.sv
// Types and constants shared by the player, laser and enemy blocks.
package game_pkg;

  typedef enum logic [2:0] {
    LS_IDLE = 3'b001,
    LS_FLY  = 3'b010,
    LS_COOL = 3'b100
  } laser_state_e;

  localparam logic [9:0] BORDER_LEFT  = 10'd9;
  localparam logic [9:0] BORDER_RIGHT = 10'd630;
  localparam logic [9:0] BORDER_TOP   = 10'd32;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic rgb_t to_rgb(input logic [11:0] c);
    return rgb_t'(c);
  endfunction

endpackage

// File: rtl/player_laser_if.sv
// Control inputs and render/score outputs of the player laser.
interface player_laser_if;

  logic       fire_i;
  logic [9:0] gun_pos_i;
  logic       alive_i;
  logic       freeze_i;
  logic       frame_tick_i;
  logic       hit_i;
  logic       laser_active_o;
  logic [9:0] laser_x_left_o;
  logic [9:0] laser_x_right_o;
  logic [9:0] laser_y_top_o;
  logic [9:0] laser_y_bot_o;
  logic       fire_ack_o;
  logic       hit_enemy_o;
  logic [3:0] laser_red_o;
  logic [3:0] laser_green_o;
  logic [3:0] laser_blue_o;
  logic [2:0] state_o;

  modport master (
    output fire_i, gun_pos_i, alive_i, freeze_i, frame_tick_i, hit_i,
    input  laser_active_o, laser_x_left_o, laser_x_right_o, laser_y_top_o,
           laser_y_bot_o, fire_ack_o, hit_enemy_o, laser_red_o,
           laser_green_o, laser_blue_o, state_o
  );

  modport slave (
    input  fire_i, gun_pos_i, alive_i, freeze_i, frame_tick_i, hit_i,
    output laser_active_o, laser_x_left_o, laser_x_right_o, laser_y_top_o,
           laser_y_bot_o, fire_ack_o, hit_enemy_o, laser_red_o,
           laser_green_o, laser_blue_o, state_o
  );

endinterface

// File: rtl/player_laser_edge_detect.sv
// Rising-edge pulse generator with asynchronous active-low reset.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sig_q <= 1'b0;
    else         sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/player_laser.sv
// Single-shot player laser: spawn on fire edge, climb per frame, retire on
// hit or top border, then wait a frame-counted cooldown.
module player_laser
  import game_pkg::*;
#(
  parameter logic [11:0] color_p      = 12'hFFF,
  parameter logic [9:0]  step_p       = 10'd4,
  parameter logic [9:0]  top_border_p = 10'd32,
  parameter logic [9:0]  spawn_y_p    = 10'd440,
  parameter logic [9:0]  width_p      = 10'd2,
  parameter logic [9:0]  height_p     = 10'd12,
  parameter logic [3:0]  cooldown_p   = 4'd8
) (
  input  logic           clk_i,
  input  logic           reset_i,
  player_laser_if.slave  bus
);

  laser_state_e state_q, state_d;
  logic [9:0]   x_left_q, x_left_d;
  logic [9:0]   y_top_q, y_top_d;
  logic [3:0]   cool_cnt_q, cool_cnt_d;
  logic         laser_active_q, laser_active_d;
  logic         fire_ack_q, fire_ack_d;
  logic         hit_enemy_q, hit_enemy_d;
  logic         fire_rise;
  rgb_t         color;

  edge_detect u_fire_edge (
    .clk_i  (clk_i),
    .rst_ni (reset_i),
    .sig_i  (bus.fire_i),
    .rise_o (fire_rise)
  );

  always_comb begin
    state_d     = state_q;
    x_left_d    = x_left_q;
    y_top_d     = y_top_q;
    cool_cnt_d  = cool_cnt_q;
    fire_ack_d  = 1'b0;
    hit_enemy_d = 1'b0;
    case (state_q)
      LS_IDLE: begin
        if (fire_rise && bus.alive_i && !bus.freeze_i) begin
          x_left_d   = bus.gun_pos_i;
          y_top_d    = spawn_y_p;
          state_d    = LS_FLY;
          fire_ack_d = 1'b1;
        end
      end
      LS_FLY: begin
        if (!bus.alive_i) begin
          state_d = LS_IDLE;
        end else if (bus.freeze_i) begin
          state_d = LS_FLY;
        end else if (bus.hit_i) begin
          hit_enemy_d = 1'b1;
          state_d     = LS_COOL;
          cool_cnt_d  = cooldown_p;
        end else if (bus.frame_tick_i) begin
          // Compare before subtracting so y_top can never wrap below zero.
          if (y_top_q < top_border_p + step_p) begin
            state_d    = LS_COOL;
            cool_cnt_d = cooldown_p;
          end else begin
            y_top_d = y_top_q - step_p;
          end
        end
      end
      LS_COOL: begin
        if (!bus.alive_i || cool_cnt_q == '0) begin
          state_d = LS_IDLE;
        end else if (bus.frame_tick_i && !bus.freeze_i) begin
          cool_cnt_d = cool_cnt_q - 4'd1;
        end
      end
      default: state_d = LS_IDLE;
    endcase
    laser_active_d = (state_d == LS_FLY);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q        <= LS_IDLE;
      x_left_q       <= '0;
      y_top_q        <= spawn_y_p;
      cool_cnt_q     <= '0;
      laser_active_q <= 1'b0;
      fire_ack_q     <= 1'b0;
      hit_enemy_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_left_q       <= x_left_d;
      y_top_q        <= y_top_d;
      cool_cnt_q     <= cool_cnt_d;
      laser_active_q <= laser_active_d;
      fire_ack_q     <= fire_ack_d;
      hit_enemy_q    <= hit_enemy_d;
    end
  end

  assign color               = to_rgb(color_p);
  assign bus.laser_active_o  = laser_active_q;
  assign bus.fire_ack_o      = fire_ack_q;
  assign bus.hit_enemy_o     = hit_enemy_q;
  assign bus.state_o         = state_q;
  assign bus.laser_x_left_o  = x_left_q;
  assign bus.laser_x_right_o = x_left_q + width_p - 10'd1;
  assign bus.laser_y_top_o   = y_top_q;
  assign bus.laser_y_bot_o   = y_top_q + height_p - 10'd1;
  assign bus.laser_red_o     = color.r;
  assign bus.laser_green_o   = color.g;
  assign bus.laser_blue_o    = color.b;

endmodule

// File: tb/tb_player_laser.sv
// Self-checking bench for player_laser: vector table plus scripted corner cases.
module tb_player_laser;

  localparam logic [2:0] S_I = 3'b001;
  localparam logic [2:0] S_F = 3'b010;
  localparam logic [2:0] S_C = 3'b100;

  typedef struct {
    logic       act;
    logic       ack;
    logic       hit;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] st;
  } exp_t;

  typedef struct {
    logic       fire;
    logic       tick;
    logic       hit;
    logic [9:0] gun;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];
  vec_t vecs[18];

  always #5 clk = ~clk;

  player_laser_if bus ();

  player_laser #(
    .color_p    (12'hFFF),
    .step_p     (10'd4),
    .top_border_p(10'd32),
    .spawn_y_p  (10'd440),
    .width_p    (10'd2),
    .height_p   (10'd12),
    .cooldown_p (4'd8)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  function automatic exp_t mk(input logic a, input logic k, input logic h,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic [2:0] s);
    exp_t e;
    e.act = a; e.ack = k; e.hit = h; e.x = x; e.y = y; e.st = s;
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    cmp({tag, ".active"}, 32'(bus.laser_active_o), 32'(e.act));
    cmp({tag, ".ack"},    32'(bus.fire_ack_o),     32'(e.ack));
    cmp({tag, ".hit"},    32'(bus.hit_enemy_o),    32'(e.hit));
    cmp({tag, ".xl"},     32'(bus.laser_x_left_o), 32'(e.x));
    cmp({tag, ".xr"},     32'(bus.laser_x_right_o), 32'(e.x) + 32'd1);
    cmp({tag, ".yt"},     32'(bus.laser_y_top_o),  32'(e.y));
    cmp({tag, ".yb"},     32'(bus.laser_y_bot_o),  32'(e.y) + 32'd11);
    cmp({tag, ".state"},  32'(bus.state_o),        32'(e.st));
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input string tag, input logic f, input logic a, input logic fr,
                      input logic t, input logic h, input logic [9:0] g, input exp_t e);
    exp_t got;
    @(negedge clk);
    bus.fire_i = f; bus.alive_i = a; bus.freeze_i = fr;
    bus.frame_tick_i = t; bus.hit_i = h; bus.gun_pos_i = g;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    compare_all(tag, got);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    bus.fire_i = 0; bus.alive_i = 1; bus.freeze_i = 0;
    bus.frame_tick_i = 0; bus.hit_i = 0; bus.gun_pos_i = 10'd300;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset", mk(0, 0, 0, 10'd0, 10'd440, S_I));
    cmp("reset.color", 32'({bus.laser_red_o, bus.laser_green_o, bus.laser_blue_o}), 32'h0FFF);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: spawn, move, hit with coincident tick, fire in COOL, cooldown
    vecs[0]  = '{0, 0, 0, 10'd300, mk(0, 0, 0, 10'd0,   10'd440, S_I)};
    vecs[1]  = '{1, 0, 0, 10'd300, mk(1, 1, 0, 10'd300, 10'd440, S_F)};
    vecs[2]  = '{0, 0, 0, 10'd300, mk(1, 0, 0, 10'd300, 10'd440, S_F)};
    vecs[3]  = '{0, 1, 0, 10'd300, mk(1, 0, 0, 10'd300, 10'd436, S_F)};
    vecs[4]  = '{0, 1, 0, 10'd300, mk(1, 0, 0, 10'd300, 10'd432, S_F)};
    vecs[5]  = '{0, 0, 0, 10'd300, mk(1, 0, 0, 10'd300, 10'd432, S_F)};
    vecs[6]  = '{0, 1, 1, 10'd300, mk(0, 0, 1, 10'd300, 10'd432, S_C)};
    vecs[7]  = '{1, 0, 0, 10'd300, mk(0, 0, 0, 10'd300, 10'd432, S_C)};
    vecs[8]  = '{0, 0, 0, 10'd300, mk(0, 0, 0, 10'd300, 10'd432, S_C)};
    for (int i = 9; i < 17; i++)
      vecs[i] = '{0, 1, 0, 10'd300, mk(0, 0, 0, 10'd300, 10'd432, S_C)};
    vecs[17] = '{0, 0, 0, 10'd300, mk(0, 0, 0, 10'd300, 10'd432, S_I)};
    for (int i = 0; i < 18; i++)
      step($sformatf("vec%0d", i), vecs[i].fire, 1, 0, vecs[i].tick, vecs[i].hit,
           vecs[i].gun, vecs[i].e);

    // Flight to the top border, miss retire, cooldown
    step("top.spawn", 1, 1, 0, 0, 0, 10'd100, mk(1, 1, 0, 10'd100, 10'd440, S_F));
    for (int k = 1; k <= 102; k++)
      step("top.fly", 0, 1, 0, 1, 0, 10'd100,
           mk(1, 0, 0, 10'd100, 10'(440 - 4 * k), S_F));
    step("top.retire", 0, 1, 0, 1, 0, 10'd100, mk(0, 0, 0, 10'd100, 10'd32, S_C));
    for (int k = 0; k < 8; k++)
      step("top.cool", 0, 1, 0, 1, 0, 10'd100, mk(0, 0, 0, 10'd100, 10'd32, S_C));
    step("top.idle", 0, 1, 0, 0, 0, 10'd100, mk(0, 0, 0, 10'd100, 10'd32, S_I));

    // Hit with coincident tick at y_top=200, fire during COOL ignored
    step("hit.spawn", 1, 1, 0, 0, 0, 10'd50, mk(1, 1, 0, 10'd50, 10'd440, S_F));
    for (int k = 1; k <= 60; k++)
      step("hit.fly", 0, 1, 0, 1, 0, 10'd50, mk(1, 0, 0, 10'd50, 10'(440 - 4 * k), S_F));
    step("hit.hit", 0, 1, 0, 1, 1, 10'd50, mk(0, 0, 1, 10'd50, 10'd200, S_C));
    step("hit.after", 0, 1, 0, 0, 0, 10'd50, mk(0, 0, 0, 10'd50, 10'd200, S_C));
    step("hit.fire", 1, 1, 0, 0, 0, 10'd77, mk(0, 0, 0, 10'd50, 10'd200, S_C));
    for (int k = 0; k < 8; k++)
      step("hit.cool", 0, 1, 0, 1, 0, 10'd77, mk(0, 0, 0, 10'd50, 10'd200, S_C));
    step("hit.idle", 0, 1, 0, 0, 0, 10'd77, mk(0, 0, 0, 10'd50, 10'd200, S_I));
    step("hit.nospawn", 0, 1, 0, 0, 0, 10'd77, mk(0, 0, 0, 10'd50, 10'd200, S_I));

    // Freeze holds position and masks hit; then alive drop skips cooldown
    step("frz.spawn", 1, 1, 0, 0, 0, 10'd400, mk(1, 1, 0, 10'd400, 10'd440, S_F));
    step("frz.t1", 0, 1, 0, 1, 0, 10'd400, mk(1, 0, 0, 10'd400, 10'd436, S_F));
    step("frz.t2", 0, 1, 0, 1, 0, 10'd400, mk(1, 0, 0, 10'd400, 10'd432, S_F));
    for (int k = 0; k < 10; k++)
      step("frz.hold", 0, 1, 1, 1, (k == 4), 10'd400, mk(1, 0, 0, 10'd400, 10'd432, S_F));
    step("frz.release", 0, 1, 0, 1, 0, 10'd400, mk(1, 0, 0, 10'd400, 10'd428, S_F));
    step("dead.drop", 0, 0, 0, 0, 0, 10'd400, mk(0, 0, 0, 10'd400, 10'd428, S_I));
    step("dead.idle", 0, 1, 0, 0, 0, 10'd400, mk(0, 0, 0, 10'd400, 10'd428, S_I));

    // Asynchronous reset mid-flight
    step("rst.spawn", 1, 1, 0, 0, 0, 10'd123, mk(1, 1, 0, 10'd123, 10'd440, S_F));
    step("rst.fly", 0, 1, 0, 1, 0, 10'd123, mk(1, 0, 0, 10'd123, 10'd436, S_F));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    compare_all("rst.async", mk(0, 0, 0, 10'd0, 10'd440, S_I));
    @(negedge clk);
    rst_n = 1'b1;

    // Held button produces exactly one spawn
    acks = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      bus.fire_i = 1; bus.alive_i = 1; bus.freeze_i = 0;
      bus.frame_tick_i = 0; bus.hit_i = 0; bus.gun_pos_i = 10'd222;
      @(posedge clk);
      #1;
      if (bus.fire_ack_o) acks++;
    end
    cmp("held.acks", 32'(acks), 32'd1);
    cmp("held.active", 32'(bus.laser_active_o), 32'd1);
    cmp("held.x", 32'(bus.laser_x_left_o), 32'd222);
    step("held.kill", 0, 0, 0, 0, 0, 10'd222, mk(0, 0, 0, 10'd222, 10'd440, S_I));

    cmp("sbq.empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
